// File: rtl/vram_rgb_param.sv
// Pixel frame buffer: one synchronous RAM, 1-cycle read port for the display,
// a write port for the renderer, and a fill engine that paints the whole screen.
module vram_rgb_param #(
    parameter int              ADDR_W     = 14,
    parameter int              BPC        = 1,
    parameter int              AUTO_CLEAR = 1,
    parameter logic [3*BPC-1:0] INIT_COLOR = '1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [BPC-1:0]      red,
    output logic [BPC-1:0]      green,
    output logic [BPC-1:0]      blue,
    input  logic                wr_en,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [3*BPC-1:0]    wr_data,
    input  logic                clr_start,
    input  logic [3*BPC-1:0]    clr_color,
    output logic                busy,
    output logic                clr_done,
    output logic [1:0]          fsm_state
);

    localparam int PIX_W = 3 * BPC;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [ADDR_W:0]    cnt;
    logic [PIX_W-1:0]   fill_color;
    logic               auto_pend;

    logic [PIX_W-1:0]   mem [DEPTH];
    logic [PIX_W-1:0]   rd_q;

    logic               fill_we;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [PIX_W-1:0]   mem_din;

    // Fill engine. auto_pend is armed during reset so the first released edge
    // behaves exactly like an accepted clr_start carrying INIT_COLOR.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            clr_done   <= 1'b0;
            fill_color <= INIT_COLOR;
            auto_pend  <= (AUTO_CLEAR != 0);
        end else begin
            case (state)
                IDLE: begin
                    if (auto_pend || clr_start) begin
                        state      <= CLEAR;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        fill_color <= auto_pend ? INIT_COLOR : clr_color;
                        auto_pend  <= 1'b0;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state    <= DONE;
                        clr_done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_state = state;

    // Write handshake: a pixel is written on a rising edge only when wr_en and
    // wr_ready are both 1; with wr_ready=0 the request is dropped, never queued.
    assign wr_ready = reset & ~busy;
    assign fill_we  = (state == CLEAR);
    assign mem_we   = reset & (fill_we | (wr_en & wr_ready));
    assign mem_addr = fill_we ? cnt[ADDR_W-1:0] : wr_addr;
    assign mem_din  = fill_we ? fill_color : wr_data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end

    // Separate read process gives read-first behaviour on address collisions.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

    assign red   = rd_q[PIX_W-1 -: BPC];
    assign green = rd_q[2*BPC-1 -: BPC];
    assign blue  = rd_q[BPC-1:0];

endmodule

// File: tb/tb_vram_rgb_param.sv
// Bench for vram_rgb_param: two instances (auto-clear on / off), directed
// stimulus, read scoreboard plus queued signal checks evaluated by one monitor.
module tb_vram_rgb_param;

    localparam int AW  = 4;
    localparam int BPC = 2;
    localparam int PW  = 3 * BPC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]  rd_addr;

    logic           reset_a, wr_en_a, clr_start_a;
    logic [AW-1:0]  wr_addr_a;
    logic [PW-1:0]  wr_data_a, clr_color_a;
    logic [BPC-1:0] red_a, green_a, blue_a;
    logic           wr_ready_a, busy_a, clr_done_a;
    logic [1:0]     fsm_state_a;

    logic           reset_b, wr_en_b, clr_start_b;
    logic [AW-1:0]  wr_addr_b;
    logic [PW-1:0]  wr_data_b, clr_color_b;
    logic [BPC-1:0] red_b, green_b, blue_b;
    logic           wr_ready_b, busy_b, clr_done_b;
    logic [1:0]     fsm_state_b;

    vram_rgb_param #(.ADDR_W(AW), .BPC(BPC), .AUTO_CLEAR(1), .INIT_COLOR(6'h3F)) u_dut_a (
        .clk(clk), .reset(reset_a), .rd_addr(rd_addr),
        .red(red_a), .green(green_a), .blue(blue_a),
        .wr_en(wr_en_a), .wr_ready(wr_ready_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .clr_start(clr_start_a), .clr_color(clr_color_a),
        .busy(busy_a), .clr_done(clr_done_a), .fsm_state(fsm_state_a)
    );

    vram_rgb_param #(.ADDR_W(AW), .BPC(BPC), .AUTO_CLEAR(0), .INIT_COLOR(6'h3F)) u_dut_b (
        .clk(clk), .reset(reset_b), .rd_addr(rd_addr),
        .red(red_b), .green(green_b), .blue(blue_b),
        .wr_en(wr_en_b), .wr_ready(wr_ready_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .clr_start(clr_start_b), .clr_color(clr_color_b),
        .busy(busy_b), .clr_done(clr_done_b), .fsm_state(fsm_state_b)
    );

    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic [10:0] exp_q[$];   // {dut, addr, pixel}
    chk_t        chk_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          fill_a = 0, done_a = 0, fill_b = 0, done_b = 0;
    logic        rd_req = 1'b0;
    logic        rd_pend = 1'b0;
    logic [10:0] mon_e;
    logic [5:0]  mon_act;
    chk_t        mon_c;

    always @(posedge clk) rd_pend <= rd_req;

    // Monitor: sole owner of the comparison counters.
    always @(negedge clk) begin
        if (busy_a && !clr_done_a) fill_a++;
        if (clr_done_a) done_a++;
        if (busy_b && !clr_done_b) fill_b++;
        if (clr_done_b) done_b++;
        if (rd_pend) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_underflow: read output with no expected entry");
            end else begin
                mon_e   = exp_q.pop_front();
                mon_act = mon_e[10] ? {red_b, green_b, blue_b} : {red_a, green_a, blue_a};
                if (mon_act !== mon_e[5:0]) begin
                    n_err++;
                    $display("FAIL rd dut=%0d addr=%0d got=%h exp=%h",
                             mon_e[10], mon_e[9:6], mon_act, mon_e[5:0]);
                end
            end
        end
        while (chk_q.size() > 0) begin
            mon_c = chk_q.pop_front();
            n_cmp++;
            if (mon_c.act !== mon_c.exp) begin
                n_err++;
                $display("FAIL %s got=%0h exp=%0h", mon_c.nm, mon_c.act, mon_c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.nm  = nm;
        c.act = act;
        c.exp = exp;
        chk_q.push_back(c);
    endtask

    task automatic rd(input logic which, input logic [AW-1:0] addr, input logic [PW-1:0] pix);
        rd_addr = addr;
        exp_q.push_back({which, addr, pix});
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic wr(input logic which, input logic [AW-1:0] addr, input logic [PW-1:0] data);
        if (which) begin
            wr_en_b = 1'b1; wr_addr_b = addr; wr_data_b = data;
        end else begin
            wr_en_a = 1'b1; wr_addr_a = addr; wr_data_a = data;
        end
        tick();
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fa, da, fb, db;
        rd_addr = '0;
        reset_a = 1'b0; wr_en_a = 1'b0; clr_start_a = 1'b0;
        wr_addr_a = '0; wr_data_a = '0; clr_color_a = '0;
        reset_b = 1'b0; wr_en_b = 1'b0; clr_start_b = 1'b0;
        wr_addr_b = '0; wr_data_b = '0; clr_color_b = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", clr_done_a, 0);
        chk("rst_wr_ready_a", wr_ready_a, 0);
        chk("rst_rgb_a", {red_a, green_a, blue_a}, 0);
        chk("rst_state_a", fsm_state_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_wr_ready_b", wr_ready_b, 0);
        chk("rst_state_b", fsm_state_b, 0);

        // Release: A auto-fills with 3F, B stays idle.
        fa = fill_a; da = done_a; fb = fill_b;
        reset_a = 1'b1; reset_b = 1'b1;
        tick();
        chk("auto_busy_a", busy_a, 1);
        chk("auto_wr_ready_a", wr_ready_a, 0);
        chk("idle_busy_b", busy_b, 0);
        repeat (24) tick();
        chk("auto_fill_cycles", fill_a - fa, 16);
        chk("auto_done_pulses", done_a - da, 1);
        chk("auto_end_busy", busy_a, 0);
        chk("auto_end_wr_ready", wr_ready_a, 1);
        chk("auto_end_state", fsm_state_a, 0);
        chk("b_no_fill", fill_b - fb, 0);
        chk("b_state_idle", fsm_state_b, 0);
        for (int i = 0; i < 16; i++) rd(1'b0, AW'(i), 6'h3F);

        // Plain write then 1-cycle read: red=2 green=1 blue=0.
        wr(1'b0, 4'd5, 6'b10_01_00);
        rd(1'b0, 4'd5, 6'h24);

        // Read-first collision at address 7.
        wr(1'b0, 4'd7, 6'h00);
        wr_en_a = 1'b1; wr_addr_a = 4'd7; wr_data_a = 6'h15;
        rd(1'b0, 4'd7, 6'h00);
        wr_en_a = 1'b0;
        rd(1'b0, 4'd7, 6'h15);

        // clr_start with a same-cycle write, a retrigger and a dropped write while busy.
        fa = fill_a; da = done_a;
        clr_start_a = 1'b1; clr_color_a = 6'h2A;
        wr_en_a = 1'b1; wr_addr_a = 4'd9; wr_data_a = 6'h11;
        tick();
        clr_start_a = 1'b0; clr_color_a = '0; wr_en_a = 1'b0;
        chk("fill2_busy", busy_a, 1);
        rd(1'b0, 4'd9, 6'h11);
        clr_start_a = 1'b1; clr_color_a = 6'h15;
        wr_en_a = 1'b1; wr_addr_a = 4'd3; wr_data_a = 6'h00;
        chk("busy_wr_ready", wr_ready_a, 0);
        tick();
        clr_start_a = 1'b0; clr_color_a = '0; wr_en_a = 1'b0;
        repeat (20) tick();
        chk("fill2_cycles", fill_a - fa, 16);
        chk("fill2_done_pulses", done_a - da, 1);
        chk("fill2_end_busy", busy_a, 0);
        for (int i = 0; i < 16; i++) rd(1'b0, AW'(i), 6'h2A);

        // Instance B: pattern, then abort a fill by reset after 8 writes.
        for (int i = 0; i < 16; i++) wr(1'b1, AW'(i), PW'(16 + i));
        fb = fill_b; db = done_b;
        clr_start_b = 1'b1; clr_color_b = 6'h3C;
        tick();
        clr_start_b = 1'b0; clr_color_b = '0;
        repeat (8) tick();
        chk("abort_pre_busy", busy_b, 1);
        rd_addr = 4'd15;
        reset_b = 1'b0;
        tick();
        chk("abort_busy", busy_b, 0);
        chk("abort_wr_ready", wr_ready_b, 0);
        chk("abort_done", clr_done_b, 0);
        chk("abort_rgb", {red_b, green_b, blue_b}, 0);
        chk("abort_state", fsm_state_b, 0);
        reset_b = 1'b1;
        repeat (3) tick();
        chk("b_post_busy", busy_b, 0);
        chk("b_post_state", fsm_state_b, 0);
        chk("b_no_done", done_b - db, 0);
        for (int i = 0; i < 16; i++) rd(1'b1, AW'(i), (i < 8) ? 6'h3C : PW'(16 + i));

        repeat (2) tick();
        chk("exp_q_drained", exp_q.size(), 0);
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vram_rgb_param.md
VRAM_RGB_PARAM -- requirements
Module: vram_rgb_param

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 14, giving pixel address width; DEPTH = 2**ADDR_W pixels.
REQ-002 The module SHALL have parameter BPC, default 1, giving bits per colour channel; PIX_W = 3*BPC.
REQ-003 The module SHALL have parameter AUTO_CLEAR, default 1: 1 = fill memory with INIT_COLOR after reset, 0 = no fill.
REQ-004 The module SHALL have parameter INIT_COLOR, default all-ones (PIX_W bits), used as the post-reset fill colour.
REQ-005 clk  input  1  single clock; all logic is on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset; 0 = reset asserted.
REQ-007 rd_addr  input  ADDR_W  display read address.
REQ-008 red  output  BPC  red channel of the pixel at the registered rd_addr.
REQ-009 green  output  BPC  green channel of that pixel.
REQ-010 blue  output  BPC  blue channel of that pixel.
REQ-011 wr_en  input  1  write request.
REQ-012 wr_ready  output  1  write port can accept a request this cycle.
REQ-013 wr_addr  input  ADDR_W  write address.
REQ-014 wr_data  input  PIX_W  write pixel, packed {red, green, blue} from MSB down.
REQ-015 clr_start  input  1  one-cycle pulse that starts a full-screen fill.
REQ-016 clr_color  input  PIX_W  fill colour, sampled on the accepted clr_start.
REQ-017 busy  output  1  fill engine is active.
REQ-018 clr_done  output  1  one-cycle pulse after the last fill write.

Function
REQ-019 The block SHALL store DEPTH words of PIX_W bits in one inferred synchronous RAM with a single read port and a single write port.
REQ-020 Read latency SHALL be exactly 1 cycle: rd_addr sampled at edge N drives red/green/blue after edge N.
REQ-021 A read and write to the same address in the same cycle SHALL return the old data (read-first).
REQ-022 The fill FSM SHALL have states IDLE, CLEAR and DONE.
REQ-023 IDLE -> CLEAR on clr_start=1: latch clr_color and load the fill counter with 0.
REQ-024 In CLEAR the FSM SHALL write the latched colour to the address equal to the counter, one address per cycle, incrementing the counter.
REQ-025 CLEAR -> DONE after the write to DEPTH-1; a full fill therefore takes exactly DEPTH cycles.
REQ-026 DONE SHALL last exactly one cycle with clr_done=1, then return to IDLE.
REQ-027 busy SHALL be 1 in CLEAR and DONE and 0 in IDLE.
REQ-028 clr_start while busy=1 SHALL be ignored.
REQ-029 The fill counter SHALL be ADDR_W+1 bits wide so the terminal test at DEPTH-1 never wraps early.
REQ-030 wr_ready SHALL equal ~busy and SHALL be 0 during reset.
REQ-031 A write SHALL occur only when wr_en=1 and wr_ready=1; a request with wr_ready=0 is dropped, not queued.
REQ-032 clr_start and wr_en asserted in the same IDLE cycle: the pixel write SHALL complete, and the fill SHALL start in the same cycle and overwrite it later.
REQ-033 Reads SHALL remain serviced during CLEAR; a pixel not yet filled returns its previous contents.

Reset
REQ-034 While reset=0 at a clock edge, the block SHALL force red/green/blue=0, busy=0, clr_done=0, wr_ready=0, and FSM state=IDLE.
REQ-035 Reset SHALL NOT clear RAM contents.
REQ-036 Reset asserted mid-fill SHALL abort the fill immediately; the unfilled region keeps its old data.
REQ-037 With AUTO_CLEAR=1, the first edge with reset=1 SHALL enter CLEAR with INIT_COLOR, exactly as an accepted clr_start.
REQ-038 With AUTO_CLEAR=0, the FSM SHALL stay in IDLE after reset.

Verification
REQ-039 Bench SHALL cover, with ADDR_W=4 and BPC=2: release reset with AUTO_CLEAR=1 and INIT_COLOR=6'h3F -> busy=1 for 16 cycles, clr_done pulses once, then every address reads red=3, green=3, blue=3.
REQ-040 Bench SHALL cover: in IDLE, write wr_addr=5, wr_data=6'b10_01_00, then set rd_addr=5 -> one cycle later red=2, green=1, blue=0.
REQ-041 Bench SHALL cover: same-cycle read and write to address 7 (old value 0, new value 6'h15) -> first output 0, next read 6'h15.
REQ-042 Bench SHALL cover: wr_en=1 during CLEAR at address 3 -> wr_ready=0, write dropped, and address 3 holds the clear colour after clr_done.
REQ-043 Bench SHALL cover: reset=0 at fill cycle 8 of 16 -> busy=0 next edge and addresses 8..15 keep their old data when AUTO_CLEAR=0.
REQ-044 Bench SHALL cover: clr_start pulsed again while busy -> ignored, and exactly one clr_done occurs.
